pipeline_bank_param: RTL and testbench

PIPELINE_BANK_PARAM -- requirements
Module: pipeline_bank_param

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_segment.sv | 174 +++++++++++++++++
 rtl/pipeline_bank_param.sv | 60 ++++++
 tb/tb_pipeline_bank_param.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM state type, clear-phase length and depth clamp helper
// used by every pipeline segment of pipeline_bank_param.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } pipe_state_e;

    // Number of cycles a segment spends in CLR before it starts filling.
    localparam int CLR_CYCLES = 2;

    // Programmed depth limited to [1, 2**aw-2]; zero behaves like one word.
    function automatic int clamp_depth(input int pdepth, input int aw);
        int max_depth;
        max_depth = (1 << aw) - 2;
        if (pdepth < 1) begin
            return 1;
        end else if (pdepth > max_depth) begin
            return max_depth;
        end else begin
            return pdepth;
        end
    endfunction

endpackage

// File: rtl/pipe_segment.sv
// pipe_segment: one delay-line segment. A 2**AW x DW RAM is filled to the
// programmed depth, then every sample strobe writes one word and retires the
// oldest one, giving a fixed delay of 'depth' samples plus two clock cycles.
module pipe_segment
    import pipe_pkg::*;
#(
    parameter int DW = 96,
    parameter int AW = 9
) (
    input  logic          rdclk,
    input  logic          rst,
    input  logic          restart,
    input  logic          we,
    input  logic [AW-1:0] pdepth,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] dout,
    output logic          dvalid,
    output logic          running,
    output logic [AW:0]   occ,
    output logic          err
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH - 1);
    localparam logic [1:0]  CLR_LAST = 2'(CLR_CYCLES - 1);

    pipe_state_e   state_q, state_d;
    logic [1:0]    clr_cnt_q, clr_cnt_d;
    logic [AW-1:0] pdepth_lat_q, pdepth_lat_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          err_q, err_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] mem [DEPTH];

    logic [AW:0]   eff_depth;
    logic          pdepth_change;
    logic          clearing;
    logic          wr_req, rd_req, wr_fire, rd_fire;

    // Effective depth derived from the value latched when CLR was left.
    always_comb begin
        eff_depth     = (AW+1)'(clamp_depth(int'(pdepth_lat_q), AW));
        pdepth_change = ((state_q == FILL) || (state_q == RUN)) && (pdepth != pdepth_lat_q);
    end

    // FSM state register.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: restart always wins, a depth change re-clears the segment.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            CLR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (pdepth_change) begin
                    state_d = CLR;
                end else if (wr_fire && ((occ_q + (AW+1)'(1)) == eff_depth)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pdepth_change) begin
                    state_d = CLR;
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = CLR;
        end
    end

    // FSM outputs: write in FILL/RUN, read only in RUN, guarded against full/empty.
    always_comb begin
        running = (state_q == RUN);
        wr_req  = we && ((state_q == FILL) || (state_q == RUN));
        rd_req  = we && (state_q == RUN);
        wr_fire = wr_req && (occ_q != OCC_FULL);
        rd_fire = rd_req && (occ_q != '0);
    end

    // Pointer, occupancy, error and output-pipeline next values.
    always_comb begin
        clearing     = (state_q == CLR) || (state_d == CLR);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        err_d        = err_q;
        clr_cnt_d    = ((state_q == CLR) && !restart) ? clr_cnt_q + 2'd1 : 2'd0;
        pdepth_lat_d = (state_q == CLR) ? pdepth : pdepth_lat_q;
        if (clearing) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            err_d    = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   occ_d = occ_q + (AW+1)'(1);
                2'b01:   occ_d = occ_q - (AW+1)'(1);
                default: occ_d = occ_q;
            endcase
            if ((wr_req && !wr_fire) || (rd_req && !rd_fire) ||
                ((state_q == RUN) && (occ_q != eff_depth))) begin
                err_d = 1'b1;
            end
        end
        rd_valid_d = rd_fire && !clearing;
        dvalid_d   = rd_valid_q && (state_d == RUN);
        dout_d     = dvalid_d ? rd_data_q : dout_q;
    end

    // Control and output registers, cleared by the asynchronous reset.
    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            clr_cnt_q    <= '0;
            pdepth_lat_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            err_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            dout_q       <= '0;
            dvalid_q     <= 1'b0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            pdepth_lat_q <= pdepth_lat_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            err_q        <= err_d;
            rd_valid_q   <= rd_valid_d;
            dout_q       <= dout_d;
            dvalid_q     <= dvalid_d;
        end
    end

    // Dual-port RAM with registered read data; contents are never reset.
    always_ff @(posedge rdclk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wdata;
        end
        if (rd_fire) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign occ    = occ_q;
    assign err    = err_q;

endmodule

// File: rtl/pipeline_bank_param.sv
// pipeline_bank_param: NSEG independent programmable-depth delay segments
// sharing one clock and one depth setting.
// Optional macro PIPE_TESTPULSE_EN: when defined, bit 0 of every written word
// is replaced by TP_PULSE while TP_SEL is high; otherwise TP_SEL/TP_PULSE are
// ignored and DIN is stored unmodified.
module pipeline_bank_param
    import pipe_pkg::*;
#(
    parameter int NSEG = 12,
    parameter int DW   = 96,
    parameter int AW   = 9
) (
    input  logic                   RDCLK,
    input  logic                   RST,
    input  logic [NSEG-1:0]        RESTART,
    input  logic [AW-1:0]          PDEPTH,
    input  logic [NSEG-1:0]        WE,
    input  logic [NSEG*DW-1:0]     DIN,
    input  logic                   TP_SEL,
    input  logic                   TP_PULSE,
    output logic [NSEG*DW-1:0]     DOUT,
    output logic [NSEG-1:0]        DVALID,
    output logic [NSEG-1:0]        RUNNING,
    output logic [NSEG*(AW+1)-1:0] OCC,
    output logic [NSEG-1:0]        ERR
);

`ifndef PIPE_TESTPULSE_EN
    logic unused_tp;
    assign unused_tp = TP_SEL ^ TP_PULSE;
`endif

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        logic [DW-1:0] seg_wdata;

`ifdef PIPE_TESTPULSE_EN
        assign seg_wdata = {DIN[s*DW+1 +: DW-1], (TP_SEL ? TP_PULSE : DIN[s*DW])};
`else
        assign seg_wdata = DIN[s*DW +: DW];
`endif

        pipe_segment #(
            .DW (DW),
            .AW (AW)
        ) u_seg (
            .rdclk   (RDCLK),
            .rst     (RST),
            .restart (RESTART[s]),
            .we      (WE[s]),
            .pdepth  (PDEPTH),
            .wdata   (seg_wdata),
            .dout    (DOUT[s*DW +: DW]),
            .dvalid  (DVALID[s]),
            .running (RUNNING[s]),
            .occ     (OCC[s*(AW+1) +: AW+1]),
            .err     (ERR[s])
        );
    end

endmodule

// File: tb/tb_pipeline_bank_param.sv
// tb_pipeline_bank_param: two-segment bench; a behavioural FIFO model of
// segment 0 pushes expected words (with their due cycle) into a scoreboard
// queue that a negedge monitor pops whenever DVALID[0] is seen.
module tb_pipeline_bank_param;

    localparam int NSEG = 2;
    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int OW   = AW + 1;

    logic                 RDCLK = 1'b0;
    logic                 RST;
    logic [NSEG-1:0]      RESTART;
    logic [AW-1:0]        PDEPTH;
    logic [NSEG-1:0]      WE;
    logic [NSEG*DW-1:0]   DIN;
    logic                 TP_SEL;
    logic                 TP_PULSE;
    logic [NSEG*DW-1:0]   DOUT;
    logic [NSEG-1:0]      DVALID;
    logic [NSEG-1:0]      RUNNING;
    logic [NSEG*OW-1:0]   OCC;
    logic [NSEG-1:0]      ERR;

    pipeline_bank_param #(.NSEG(NSEG), .DW(DW), .AW(AW)) dut (
        .RDCLK    (RDCLK),
        .RST      (RST),
        .RESTART  (RESTART),
        .PDEPTH   (PDEPTH),
        .WE       (WE),
        .DIN      (DIN),
        .TP_SEL   (TP_SEL),
        .TP_PULSE (TP_PULSE),
        .DOUT     (DOUT),
        .DVALID   (DVALID),
        .RUNNING  (RUNNING),
        .OCC      (OCC),
        .ERR      (ERR)
    );

    always #5 RDCLK = ~RDCLK;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    typedef struct {
        logic [AW-1:0] pdepth;
        int            depth;
    } depth_vec_t;

    typedef enum {M_IDLE, M_CLR, M_FILL, M_RUN} mstate_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    exp_t          mon_e;
    logic [DW-1:0] last_data = '0;
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    mstate_t       m_state = M_IDLE;
    int            clr_left = 0;
    logic [AW-1:0] m_lat = '0;
    int            m_depth = 1;

    always @(posedge RDCLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drop expected words whose output edge has not yet happened.
    task automatic flush_pending();
        while (exp_q.size() > 0 && exp_q[$].due > cyc) begin
            void'(exp_q.pop_back());
        end
    endtask

    task automatic model_clear();
        m_state  = M_CLR;
        clr_left = 2;
        fifo_q.delete();
        flush_pending();
    endtask

    // Drive one cycle of inputs, update the segment-0 model for the coming
    // edge, then advance to 1 time unit after that edge.
    task automatic apply_stimulus(input logic [NSEG-1:0] restart, input logic [NSEG-1:0] we,
                                  input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [DW-1:0] w;
        logic [DW-1:0] old;
        RESTART = restart;
        WE      = we;
        DIN     = {d1, d0};
        w       = d0;
`ifdef PIPE_TESTPULSE_EN
        w[0] = TP_SEL ? TP_PULSE : d0[0];
`endif
        if (restart[0]) begin
            model_clear();
        end else begin
            case (m_state)
                M_CLR: begin
                    clr_left--;
                    if (clr_left == 0) begin
                        m_state = M_FILL;
                        m_lat   = PDEPTH;
                        m_depth = (PDEPTH == 0) ? 1 : ((int'(PDEPTH) > 14) ? 14 : int'(PDEPTH));
                    end
                end
                M_FILL: begin
                    if (PDEPTH != m_lat) begin
                        model_clear();
                    end else if (we[0]) begin
                        fifo_q.push_back(w);
                        if (fifo_q.size() == m_depth) m_state = M_RUN;
                    end
                end
                M_RUN: begin
                    if (PDEPTH != m_lat) begin
                        model_clear();
                    end else if (we[0]) begin
                        fifo_q.push_back(w);
                        old = fifo_q.pop_front();
                        exp_q.push_back('{data: old, due: cyc + 2});
                    end
                end
                default: ;
            endcase
        end
        @(posedge RDCLK);
        #1;
        RESTART = '0;
    endtask

    // Scoreboard monitor for segment 0 output words.
    always @(negedge RDCLK) begin
        if (!RST) begin
            if (DVALID[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_dvalid: got %0h expected none (cycle %0d)", DOUT[DW-1:0], cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    last_data = mon_e.data;
                    if (DOUT[DW-1:0] !== mon_e.data || cyc != mon_e.due || !RUNNING[0]) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_dout: got %0h at cycle %0d running %0b expected %0h at cycle %0d",
                                 DOUT[DW-1:0], cyc, RUNNING[0], mon_e.data, mon_e.due);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_dvalid: got nothing expected %0h at cycle %0d", mon_e.data, mon_e.due);
            end
        end
    end

    depth_vec_t tbl[6];
    int         data_cnt = 0;

    function automatic logic [DW-1:0] next_data();
        data_cnt++;
        return DW'(data_cnt * 16'h0102);
    endfunction

    initial begin
        tbl[0] = '{pdepth: 4'd5,  depth: 5};
        tbl[1] = '{pdepth: 4'd0,  depth: 1};
        tbl[2] = '{pdepth: 4'd1,  depth: 1};
        tbl[3] = '{pdepth: 4'd15, depth: 14};
        tbl[4] = '{pdepth: 4'd14, depth: 14};
        tbl[5] = '{pdepth: 4'd2,  depth: 2};

        RST = 1'b1; RESTART = '0; WE = '0; PDEPTH = 4'd5; DIN = '0; TP_SEL = 1'b0; TP_PULSE = 1'b0;
        repeat (2) @(posedge RDCLK);
        #1;
        check_output("reset_running", 64'(RUNNING), 64'd0);
        check_output("reset_occ", 64'(OCC), 64'd0);
        check_output("reset_err_dvalid", 64'({ERR, DVALID}), 64'd0);
        check_output("reset_dout", 64'(DOUT), 64'd0);
        RST = 1'b0;

        // Strobes before any restart are ignored.
        repeat (3) apply_stimulus(2'b00, 2'b11, next_data(), next_data());
        check_output("idle_occ", 64'(OCC), 64'd0);

        // Basic fill and run with depth 5; segment 1 never restarted.
        PDEPTH = 4'd5;
        apply_stimulus(2'b01, 2'b01, next_data(), 16'h0);
        check_output("clr_running", 64'(RUNNING[0]), 64'd0);
        repeat (2) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("clr_ignores_we", 64'(OCC[OW-1:0]), 64'd0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
            if (i == 2) check_output("fill_occ3", 64'(OCC[OW-1:0]), 64'd3);
            if (i == 3) check_output("fill_not_running", 64'(RUNNING[0]), 64'd0);
        end
        check_output("run_entered", 64'(RUNNING[0]), 64'd1);
        repeat (10) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("run_occ_plateau", 64'(OCC[OW-1:0]), 64'd5);
        check_output("seg1_idle", 64'({RUNNING[1], DVALID[1], OCC[2*OW-1:OW]}), 64'd0);
        repeat (3) apply_stimulus(2'b00, 2'b00, next_data(), 16'h0);
        check_output("dout_hold", 64'({DVALID[0], DOUT[DW-1:0]}), 64'({1'b0, last_data}));

        // Depth change while running forces a re-clear and refill.
        PDEPTH = 4'd8;
        apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("pchg_clr", 64'({RUNNING[0], OCC[OW-1:0]}), 64'd0);
        repeat (2) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        repeat (7) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("pchg_fill7", 64'({RUNNING[0], OCC[OW-1:0]}), 64'({1'b0, 5'd7}));
        apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("pchg_run8", 64'({RUNNING[0], OCC[OW-1:0]}), 64'({1'b1, 5'd8}));
        repeat (4) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);

        // Depth clamping table.
        for (int i = 0; i < 6; i++) begin
            PDEPTH = tbl[i].pdepth;
            apply_stimulus(2'b01, 2'b01, next_data(), 16'h0);
            repeat (2) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
            for (int j = 0; j < tbl[i].depth - 1; j++) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
            check_output($sformatf("tbl%0d_prefill", i), 64'({RUNNING[0], OCC[OW-1:0]}),
                         64'({1'b0, 5'(tbl[i].depth - 1)}));
            apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
            check_output($sformatf("tbl%0d_run", i), 64'({RUNNING[0], OCC[OW-1:0]}),
                         64'({1'b1, 5'(tbl[i].depth)}));
            repeat (4) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
            check_output($sformatf("tbl%0d_plateau", i), 64'({ERR[0], OCC[OW-1:0]}),
                         64'({1'b0, 5'(tbl[i].depth)}));
        end

        // Test pulse: bit 0 of DIN is always 1, the pulse is a single cycle.
        PDEPTH = 4'd5;
        TP_SEL = 1'b1;
        apply_stimulus(2'b01, 2'b01, 16'h0, 16'h0);
        repeat (2) apply_stimulus(2'b00, 2'b01, 16'h0, 16'h0);
        for (int i = 0; i < 12; i++) begin
            TP_PULSE = (i == 2);
            apply_stimulus(2'b00, 2'b01, 16'((i << 4) | 1), 16'h0);
        end
        TP_PULSE = 1'b0;
        TP_SEL   = 1'b0;
        repeat (3) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);

        // Reset in the middle of RUN.
        check_output("pre_rst_occ", 64'(OCC[OW-1:0]), 64'd5);
        RST = 1'b1;
        m_state = M_IDLE;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check_output("rst_async_outputs", 64'({RUNNING, DVALID, ERR, OCC}), 64'd0);
        check_output("rst_async_dout", 64'(DOUT), 64'd0);
        @(posedge RDCLK);
        #1;
        RST = 1'b0;
        repeat (4) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("post_rst_no_write", 64'({RUNNING[0], DVALID[0], OCC[OW-1:0]}), 64'd0);

        // Forced occupancy mismatch in RUN sets a sticky error.
        apply_stimulus(2'b01, 2'b01, next_data(), 16'h0);
        repeat (7) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("err_pre", 64'({RUNNING[0], ERR[0]}), 64'b10);
        force dut.g_seg[0].u_seg.occ_q = 5'd3;
        apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0);
        release dut.g_seg[0].u_seg.occ_q;
        check_output("err_set", 64'(ERR[0]), 64'd1);
        repeat (2) apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0);
        check_output("err_sticky", 64'(ERR[0]), 64'd1);
        apply_stimulus(2'b01, 2'b00, 16'h0, 16'h0);
        check_output("err_cleared", 64'({ERR[0], OCC[OW-1:0]}), 64'd0);
        repeat (2) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        repeat (8) apply_stimulus(2'b00, 2'b01, next_data(), 16'h0);
        check_output("err_stays_clear", 64'({RUNNING[0], ERR[0]}), 64'b10);

        repeat (4) apply_stimulus(2'b00, 2'b00, 16'h0, 16'h0);
        check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
